// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, functs,
// FSM state encoding, instruction classes, ALU op codes and pc_src codes.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam int ALU_ADD = 0;
   localparam int ALU_SUB = 1;
   localparam int ALU_OR  = 2;
   localparam int ALU_LUI = 3;
   localparam int ALU_SLL = 4;

   localparam logic [1:0] PC_SEQ  = 2'd0;
   localparam logic [1:0] PC_BR   = 2'd1;
   localparam logic [1:0] PC_JUMP = 2'd2;
   localparam logic [1:0] PC_REG  = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      C_ADDU, C_SUBU, C_SLL, C_SLLV, C_JR,
      C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL,
      C_ILL
   } cls_t;

   function automatic logic is_rtype(input cls_t c);
      return (c == C_ADDU) || (c == C_SUBU) || (c == C_SLL) || (c == C_SLLV);
   endfunction

   // Instructions that complete in EXEC by redirecting the PC.
   function automatic logic is_ctrl_flow(input cls_t c);
      return (c == C_BEQ) || (c == C_J) || (c == C_JAL) || (c == C_JR);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct -> class, plus an
// unknown flag for anything outside the supported subset.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output cls_t       cls,
   output logic       unknown
);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      cls = C_ILL;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: cls = C_ADDU;
               FN_SUBU: cls = C_SUBU;
               FN_SLL:  cls = C_SLL;
               FN_SLLV: cls = C_SLLV;
               FN_JR:   cls = C_JR;
               default: cls = C_ILL;
            endcase
         end
         OP_ORI:  cls = C_ORI;
         OP_LUI:  cls = C_LUI;
         OP_LW:   cls = C_LW;
         OP_SW:   cls = C_SW;
         OP_BEQ:  cls = C_BEQ;
         OP_J:    cls = C_J;
         OP_JAL:  cls = C_JAL;
         default: cls = C_ILL;
      endcase
   end

   assign unknown = (cls == C_ILL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with a DM handshake.
// Define MC_CTRL_INSTR_CNT_EN to build the retired-instruction counter.
module mc_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int ALUOP_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               dm_ready,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               reg_write,
   output logic               dm_req,
   output logic               mem_write,
   output logic               RegDst,
   output logic               ralink,
   output logic               MemtoReg,
   output logic               PCtoReg,
   output logic               shiftvar,
   output logic               ALUSrc,
   output logic               ext_op,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               illegal,
   output logic [2:0]         state_o
`ifdef MC_CTRL_INSTR_CNT_EN
   ,
   output logic [31:0]        instr_cnt
`endif
);

   state_t state;
   cls_t   cls;
   logic   unknown;

   ctrl_decode u_decode (
      .opcode  (opcode),
      .funct   (funct),
      .cls     (cls),
      .unknown (unknown)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: state <= unknown ? S_FETCH : S_EXEC;
            S_EXEC: begin
               if ((cls == C_LW) || (cls == C_SW))
                  state <= S_MEM;
               else if (is_ctrl_flow(cls))
                  state <= S_FETCH;
               else
                  state <= S_WB;
            end
            S_MEM: begin
               if (dm_ready)
                  state <= (cls == C_SW) ? S_FETCH : S_WB;
            end
            S_WB:     state <= S_FETCH;
            default:  state <= S_FETCH;
         endcase
      end
   end

   assign state_o = state;

   // NOTE: outputs are gated by reset directly so no strobe survives the instant reset rises.
   always_comb begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SEQ;
      reg_write = 1'b0;
      dm_req    = 1'b0;
      mem_write = 1'b0;
      RegDst    = 1'b0;
      ralink    = 1'b0;
      MemtoReg  = 1'b0;
      PCtoReg   = 1'b0;
      shiftvar  = 1'b0;
      ALUSrc    = 1'b0;
      ext_op    = 1'b0;
      alu_op    = ALUOP_W'(ALU_ADD);
      illegal   = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
            S_DECODE: illegal = unknown;
            S_EXEC: begin
               case (cls)
                  C_ADDU: alu_op = ALUOP_W'(ALU_ADD);
                  C_SUBU: alu_op = ALUOP_W'(ALU_SUB);
                  C_SLL:  alu_op = ALUOP_W'(ALU_SLL);
                  C_SLLV: begin
                     alu_op   = ALUOP_W'(ALU_SLL);
                     shiftvar = 1'b1;
                  end
                  C_ORI: begin
                     ALUSrc = 1'b1;
                     alu_op = ALUOP_W'(ALU_OR);
                  end
                  C_LUI: begin
                     ALUSrc = 1'b1;
                     alu_op = ALUOP_W'(ALU_LUI);
                  end
                  C_LW, C_SW: begin
                     ALUSrc = 1'b1;
                     ext_op = 1'b1;
                     alu_op = ALUOP_W'(ALU_ADD);
                  end
                  C_BEQ: begin
                     alu_op   = ALUOP_W'(ALU_SUB);
                     pc_src   = PC_BR;
                     pc_write = zero;
                  end
                  C_J: begin
                     pc_write = 1'b1;
                     pc_src   = PC_JUMP;
                  end
                  C_JAL: begin
                     pc_write  = 1'b1;
                     pc_src    = PC_JUMP;
                     reg_write = 1'b1;
                     ralink    = 1'b1;
                     PCtoReg   = 1'b1;
                  end
                  C_JR: begin
                     pc_write = 1'b1;
                     pc_src   = PC_REG;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               dm_req    = 1'b1;
               mem_write = (cls == C_SW);
            end
            S_WB: begin
               reg_write = 1'b1;
               RegDst    = is_rtype(cls);
               MemtoReg  = (cls == C_LW);
            end
            default: ;
         endcase
      end
   end

`ifdef MC_CTRL_INSTR_CNT_EN
   logic retire;

   // An instruction retires on the edge that returns the FSM to FETCH;
   // the illegal DECODE exit is deliberately excluded.
   assign retire = ((state == S_EXEC) && is_ctrl_flow(cls))
                || ((state == S_MEM) && dm_ready && (cls == C_SW))
                || (state == S_WB);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         instr_cnt <= '0;
      else if (retire)
         instr_cnt <= instr_cnt + 32'd1;
   end
`endif

endmodule
